// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the wait-state memory responder.
package mem_resp_pkg;

    localparam int WORD_W          = 32;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int DEPTH_LOG2_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // A request is unusable if it is misaligned or asks for read and write at once.
    function automatic logic req_is_bad(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd & wr) | (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit and the memory responder.
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/word_ram.sv
// Single-port backing store, synchronous read and write, never cleared.
module word_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // One access per enabled cycle: write commits, or the addressed word is registered out.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, inserts wait states, accesses the store, pulses ready.
//
// state    | meaning
// S_IDLE   | waiting for mem_read/mem_write; request latched on the accepting edge
// S_WAIT   | wait-state down-counter running, leaves when it reaches 1
// S_ACCESS | store write commits / synchronous read issued on the leaving edge
// S_RESP   | ready (and err if the request was bad) for one cycle
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  bad_q, bad_d;
    logic [DEPTH_LOG2-1:0] widx_q, widx_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic [WORD_W-1:0]     ram_rdata;
    logic                  ram_en;
    logic                  good_read_resp;
    logic                  unused_addr_hi;

    // Address bits above the word index wrap away by design.
    assign unused_addr_hi = ^bus.addr[WORD_W-1:DEPTH_LOG2+2];

    // A bad request never touches the store, so reset in ACCESS also blocks the write.
    assign ram_en         = (state_q == S_ACCESS) && !bad_q;
    assign good_read_resp = (state_q == S_RESP) && rd_q && !bad_q;

    word_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WORD_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (wr_q),
        .addr_i  (widx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next-state logic: request capture, wait countdown, and load-data hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    rd_d    = bus.mem_read;
                    wr_d    = bus.mem_write;
                    bad_d   = req_is_bad(bus.mem_read, bus.mem_write, bus.addr[1:0]);
                    widx_d  = bus.addr[DEPTH_LOG2+1:2];
                    wdata_d = bus.wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP: begin
                state_d = S_IDLE;
                if (good_read_resp) begin
                    rdata_d = ram_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and transaction registers; store contents are deliberately outside reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Load data is live from the store during RESP and held from the register otherwise.
    assign bus.rdata = good_read_resp ? ram_rdata : rdata_q;
    assign bus.ready = (state_q == S_RESP);
    assign bus.err   = (state_q == S_RESP) && bad_q;
    assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of wait-state cycles inserted before each access (legal range 0..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: log2 of the backing store depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_read  input  1  read request from the control unit.
REQ-006 SHALL have port mem_write  input  1  write request from the control unit.
REQ-007 SHALL have port addr  input  32  byte address (already muxed PC/ALUOut by the requester's IorD).
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port rdata  output  32  load/fetch data, valid while ready=1 and held afterwards.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high from acceptance until the end of the ready cycle.
REQ-012 SHALL have port err  output  1  one-cycle error pulse, coincident with ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-014 In IDLE, a request (mem_read|mem_write) SHALL be accepted on the rising edge: latch op, addr, wdata; go to WAIT, or to ACCESS if WAIT_CYCLES=0.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded at acceptance.
REQ-016 ACCESS SHALL last one cycle: a write commits to the store on the edge leaving ACCESS; a read issues the synchronous store read.
REQ-017 RESP SHALL last one cycle with ready=1; for reads, rdata SHALL equal the store word; the next state is IDLE.
REQ-018 Latency SHALL be WAIT_CYCLES+2 cycles from the acceptance edge to ready high (4 at default).
REQ-019 Request inputs SHALL be ignored while busy=1; a request still asserted in IDLE after RESP SHALL be accepted as a new request.
REQ-020 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-021 A request with addr[1:0]≠0 SHALL NOT access the store and SHALL complete with the normal latency, ready=1 and err=1; rdata SHALL be unchanged.
REQ-022 A request with mem_read=1 and mem_write=1 together SHALL be treated as erroneous: no store access, completion with ready=1 and err=1.
REQ-023 rdata SHALL change only in the RESP cycle of a successful read.

Reset
REQ-024 On rst=0, the block SHALL asynchronously go to IDLE with busy=0, ready=0, err=0, rdata=0 and the wait counter cleared.
REQ-025 Reset during WAIT or ACCESS SHALL abort the transaction; a pending write SHALL NOT commit.
REQ-026 Store contents SHALL NOT be cleared by reset.

Structure
REQ-027 Package mem_resp_pkg SHALL hold the state encoding, the WAIT_CYCLES/DEPTH_LOG2 defaults and the word width constant.
REQ-028 The backing store SHALL be a separate sub-module word_ram: single-port, synchronous read and write, 2^DEPTH_LOG2 x 32.

Verification
REQ-029 Write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> ready 4 cycles after each acceptance; rdata=0xDEADBEEF; err=0.
REQ-030 Read addr 0x13 -> ready and err pulse together after 4 cycles; store and rdata unchanged.
REQ-031 Assert mem_read and mem_write together at addr 0x20 -> err=1 with ready; a following read of 0x20 returns the previous value.
REQ-032 Write 0x12345678 to addr 0x40 and pull rst low during WAIT -> outputs at reset values; a later read of 0x40 returns the old value.
REQ-033 Hold mem_read high at addr 0x0 for 12 cycles -> exactly two ready pulses (next acceptance in the cycle after RESP); a change to addr while busy has no effect.
REQ-034 With DEPTH_LOG2=8, write 0xA5A5A5A5 to 0x400, then read 0x000 -> returns 0xA5A5A5A5 (address wrap).
